// File: rtl/gate_sweep_checker.sv
// -----------------------------------------------------------------------------
// gate_sweep_checker
//
// Exhaustive truth-table engine for an N_IN-input combinational cell with a
// single output. It steps every input pattern from 0 to 2^N_IN-1 onto the cell
// under test. Each pattern is held for SETTLE cycles and then ZN is sampled.
// The sample is compared against a selectable reference function. The block
// reports the number of failing patterns and the lowest failing pattern.
//
// Parameters
//   N_IN    number of cell inputs (1..8)
//   SETTLE  cycles each pattern is held before ZN is sampled (1..255)
//
// Ports
//   ck_i          clock, all state changes on the rising edge
//   rst_i         synchronous reset, active high; aborts any sweep
//   start_i       begin a sweep; only looked at while idle
//   op_i          reference function, latched when a sweep starts:
//                 0 NOR, 1 NAND, 2 OR, 3 AND, 4 XOR, 5 XNOR, 6/7 reserved
//   a_o           pattern driven to the cell; a_o[N_IN-1] is input A1
//   zn_i          cell output
//   busy_o        high from the cycle after acceptance through the done cycle
//   done_o        one-cycle pulse when the sweep is finished
//   pass_o        last sweep had zero mismatches and a legal op
//   err_cnt_o     number of mismatching patterns (up to 2^N_IN)
//   fail_valid_o  at least one mismatch has been recorded
//   first_fail_o  lowest failing pattern, meaningful with fail_valid_o
// -----------------------------------------------------------------------------
module gate_sweep_checker #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  logic            ck_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  output logic [N_IN-1:0] a_o,
  input  logic            zn_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic [N_IN:0]   err_cnt_o,
  output logic            fail_valid_o,
  output logic [N_IN-1:0] first_fail_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_FIN    = 2'd3
  } state_e;

  // The settle counter counts down to zero, so a pattern spends SETTLE
  // cycles in S_SETTLE followed by one cycle in S_CHECK.
  localparam logic [7:0]      SETTLE_RELOAD = 8'(SETTLE - 1);
  localparam logic [N_IN-1:0] ALL_ONES      = {N_IN{1'b1}};

  // Ops 6 and 7 are reserved. A sweep requested with them finishes at once
  // and never reports a pass.
  function automatic logic op_legal(input logic [2:0] op);
    op_legal = (op <= 3'd5);
  endfunction

  // Reference output of the selected function. XOR and XNOR are full
  // reduction parity over every input.
  function automatic logic ref_fn(input logic [2:0] op, input logic [N_IN-1:0] pat);
    case (op)
      3'd0:    ref_fn = ~(|pat);
      3'd1:    ref_fn = ~(&pat);
      3'd2:    ref_fn = |pat;
      3'd3:    ref_fn = &pat;
      3'd4:    ref_fn = ^pat;
      3'd5:    ref_fn = ~(^pat);
      default: ref_fn = 1'b0;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [N_IN-1:0] a_q, a_d;
  logic [N_IN:0]   err_q, err_d;
  logic            fv_q, fv_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            pass_q, pass_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            exp_s;
  logic            mism_s;
  logic [N_IN:0]   err_inc_s;

  // State and result registers, cleared by synchronous reset.
  always_ff @(posedge ck_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      op_q    <= 3'd0;
      a_q     <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ff_q    <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state selection for the sweep sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = op_legal(op_i) ? S_SETTLE : S_FIN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = S_CHECK;
        end else begin
          state_d = S_SETTLE;
        end
      end
      S_CHECK: begin
        if (a_q == ALL_ONES) begin
          state_d = S_FIN;
        end else begin
          state_d = S_SETTLE;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sample comparison. The case-inequality makes an X or Z on zn_i count as
  // a mismatch in four-state simulation.
  always_comb begin
    exp_s     = ref_fn(op_q, a_q);
    mism_s    = (zn_i !== exp_s);
    err_inc_s = err_q + {{N_IN{1'b0}}, mism_s};
  end

  // Datapath and output next values for each state.
  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    a_d    = a_q;
    err_d  = err_q;
    fv_d   = fv_q;
    ff_d   = ff_q;
    pass_d = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          // Results of the previous sweep are dropped when a new one starts.
          // The reserved-op path also clears them and goes straight to S_FIN
          // with pass_o held at 0.
          cnt_d  = SETTLE_RELOAD;
          op_d   = op_i;
          a_d    = '0;
          err_d  = '0;
          fv_d   = 1'b0;
          ff_d   = '0;
          pass_d = 1'b0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_SETTLE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_CHECK: begin
        err_d = err_inc_s;
        if (mism_s && !fv_q) begin
          ff_d = a_q;
          fv_d = 1'b1;
        end else begin
          ff_d = ff_q;
        end
        if (a_q == ALL_ONES) begin
          // pass_o is computed here so that it is already valid in the done
          // cycle, and it includes the final pattern's result.
          pass_d = (err_inc_s == '0) && op_legal(op_q);
        end else begin
          a_d   = a_q + {{(N_IN-1){1'b0}}, 1'b1};
          cnt_d = SETTLE_RELOAD;
        end
      end
      S_FIN: begin
        a_d = '0;
      end
      default: begin
        a_d = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  assign a_o          = a_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign err_cnt_o    = err_q;
  assign fail_valid_o = fv_q;
  assign first_fail_o = ff_q;

endmodule
